// File: rtl/alu_link_arbiter_if.sv
// rtl/alu_link_arbiter_if.sv - requester-side and ALU-side link signals of the ALU link arbiter
interface alu_link_arbiter_if #(
  parameter int NUM_REQUESTERS = 4
) ();
  logic [NUM_REQUESTERS-1:0]         i_req_nss;
  logic [NUM_REQUESTERS-1:0]         i_req_mosi;
  logic [NUM_REQUESTERS-1:0]         o_req_miso;
  logic                              o_alu_nss;
  logic                              o_alu_mosi;
  logic                              i_alu_miso;
  logic                              o_grant_valid;
  logic [$clog2(NUM_REQUESTERS)-1:0] o_grant_id;
  logic                              o_timeout;

  modport master (
    input  i_req_nss, i_req_mosi, i_alu_miso,
    output o_req_miso, o_alu_nss, o_alu_mosi, o_grant_valid, o_grant_id, o_timeout
  );

  modport slave (
    output i_req_nss, i_req_mosi, i_alu_miso,
    input  o_req_miso, o_alu_nss, o_alu_mosi, o_grant_valid, o_grant_id, o_timeout
  );
endinterface

// File: rtl/alu_link_arbiter.sv
// rtl/alu_link_arbiter.sv - round-robin arbiter sharing one serial ALU link among SPI masters
// Grants are held for a whole nss-low transaction; a watchdog revokes overlong grants.
module alu_link_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               i_clock,
  input  logic               i_reset,
  alu_link_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(NUM_REQUESTERS);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQUESTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ACTIVE,
    S_ABORT,
    S_RELEASE
  } state_t;

  state_t                    state;
  logic [ID_W-1:0]           grant_id;
  logic [ID_W-1:0]           last_id;
  logic [CNT_W-1:0]          wd_count;
  logic                      timeout_q;
  logic [ID_W-1:0]           cand;
  logic [ID_W-1:0]           pick_id;
  logic                      pick_found;
  logic                      owner_nss;
  logic [NUM_REQUESTERS-1:0] miso_mux;

  // Search starts just past the previous owner so every requester gets a turn.
  always_comb begin
    cand       = '0;
    pick_id    = '0;
    pick_found = 1'b0;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      cand = ID_W'((int'(last_id) + i) % NUM_REQUESTERS);
      if (!pick_found && !bus.i_req_nss[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign owner_nss = bus.i_req_nss[grant_id];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= S_IDLE;
      grant_id  <= '0;
      last_id   <= ID_LAST;
      wd_count  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          // A release seen on the last watchdog cycle wins over the timeout.
          if (owner_nss) begin
            state <= S_RELEASE;
          end else if (wd_count == CNT_LAST) begin
            state     <= S_ABORT;
            timeout_q <= 1'b1;
          end else begin
            wd_count <= wd_count + CNT_W'(1);
          end
        end
        S_ABORT: begin
          if (owner_nss) begin
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          last_id  <= grant_id;
          wd_count <= '0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Idle miso lines sit high so waiting masters stay in their pre-send handshake.
  always_comb begin
    miso_mux = '1;
    if (state == S_ACTIVE) begin
      miso_mux[grant_id] = bus.i_alu_miso;
    end
  end

  assign bus.o_req_miso    = miso_mux;
  assign bus.o_alu_nss     = (state != S_ACTIVE);
  assign bus.o_alu_mosi    = (state == S_ACTIVE) && bus.i_req_mosi[grant_id];
  assign bus.o_grant_valid = (state == S_GRANT) || (state == S_ACTIVE) || (state == S_ABORT);
  assign bus.o_grant_id    = grant_id;
  assign bus.o_timeout     = timeout_q;
endmodule

// File: tb/tb_alu_link_arbiter.sv
// tb/tb_alu_link_arbiter.sv - bench for alu_link_arbiter against a transaction-level link model
module tb_alu_link_arbiter;
  localparam int NR = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_link_arbiter_if #(.NUM_REQUESTERS(NR)) bus ();

  alu_link_arbiter #(
    .NUM_REQUESTERS(NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Link model: owner (-1 = none), age counts cycles since the grant began
  // (0 = settle, 1..TO = connected), plus an aborted flag and a one-cycle gap.
  int m_owner   = -1;
  int m_age     = 0;
  int m_last    = NR - 1;
  int m_gid     = 0;
  bit m_aborted = 1'b0;
  bit m_gap     = 1'b0;
  bit m_tp      = 1'b0;

  task automatic model_step();
    m_tp = 1'b0;
    if (rst) begin
      m_owner = -1; m_age = 0; m_last = NR - 1; m_gid = 0;
      m_aborted = 1'b0; m_gap = 1'b0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner < 0) begin
      for (int d = 1; d <= NR; d++) begin
        if (m_owner < 0 && !bus.i_req_nss[(m_last + d) % NR]) begin
          m_owner = (m_last + d) % NR;
          m_gid   = m_owner;
          m_age   = 0;
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (bus.i_req_nss[m_owner]) begin
      m_last = m_owner; m_owner = -1; m_gap = 1'b1; m_aborted = 1'b0;
    end else if (!m_aborted) begin
      if (m_age == TO) begin
        m_aborted = 1'b1;
        m_tp      = 1'b1;
      end else begin
        m_age++;
      end
    end
  endtask

  always @(posedge clk) model_step();

  bit          conn;
  logic        exp_mosi;
  logic [NR-1:0] exp_miso;

  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      conn     = (m_owner >= 0) && (m_age >= 1) && !m_aborted;
      exp_miso = '1;
      exp_mosi = 1'b0;
      if (conn) begin
        exp_miso[m_owner] = bus.i_alu_miso;
        exp_mosi          = bus.i_req_mosi[m_owner];
      end
      check("alu_nss",     32'(bus.o_alu_nss),     32'(!conn));
      check("alu_mosi",    32'(bus.o_alu_mosi),    32'(exp_mosi));
      check("req_miso",    32'(bus.o_req_miso),    32'(exp_miso));
      check("grant_valid", 32'(bus.o_grant_valid), 32'(m_owner >= 0));
      check("grant_id",    32'(bus.o_grant_id),    32'(m_gid));
      check("timeout",     32'(bus.o_timeout),     32'(m_tp));
    end
  end

  initial begin
    bus.i_req_mosi = '0;
    bus.i_alu_miso = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_req_mosi = NR'($urandom());
      bus.i_alu_miso = 1'($urandom());
    end
  end

  task automatic wait_active(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); #2;
      ok = bus.o_grant_valid && !bus.o_alu_nss;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  logic [NR-1:0] nss_v;
  int hold [NR];
  int gid, prev, gap, act;
  bit ok;

  initial begin
    nss_v = '1;
    bus.i_req_nss = nss_v;
    rst = 1'b1;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check("rst_alu_nss", 32'(bus.o_alu_nss), 32'd1);
    check("rst_miso",    32'(bus.o_req_miso), 32'hF);
    check("rst_gv",      32'(bus.o_grant_valid), 32'd0);
    check("rst_gid",     32'(bus.o_grant_id), 32'd0);
    check("rst_timeout", 32'(bus.o_timeout), 32'd0);
    cmp_en = 1'b1;
    @(negedge clk); rst = 1'b0;

    // single requester 2
    @(negedge clk); nss_v = 4'b1011; bus.i_req_nss = nss_v;
    @(negedge clk); #2;
    check("single_grant_gv",  32'(bus.o_grant_valid), 32'd1);
    check("single_grant_id",  32'(bus.o_grant_id), 32'd2);
    check("single_grant_nss", 32'(bus.o_alu_nss), 32'd1);
    @(negedge clk); #2;
    check("single_active_nss", 32'(bus.o_alu_nss), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      check("single_mosi",   32'(bus.o_alu_mosi), 32'(bus.i_req_mosi[2]));
      check("single_miso",   32'(bus.o_req_miso[2]), 32'(bus.i_alu_miso));
      check("single_others", 32'(bus.o_req_miso | 4'b0100), 32'hF);
    end
    @(negedge clk); nss_v = '1; bus.i_req_nss = nss_v;
    repeat (4) @(negedge clk);

    // round-robin fairness from a fresh reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; nss_v = '0; bus.i_req_nss = nss_v;
    prev = -1;
    for (int g = 0; g < 5; g++) begin
      gap = 0; ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (i == 0 && prev >= 0) begin
          nss_v[prev] = 1'b0; bus.i_req_nss = nss_v;
        end
        #2;
        if (bus.o_grant_valid && !bus.o_alu_nss) ok = 1'b1;
        else gap++;
      end
      gid = int'(bus.o_grant_id);
      check("rr_found", 32'(ok), 32'd1);
      check("rr_order", 32'(gid), 32'(g % NR));
      if (g > 0) check("rr_gap", 32'(gap), 32'd3);
      repeat (4) @(negedge clk);
      @(negedge clk); nss_v[gid] = 1'b1; bus.i_req_nss = nss_v; prev = gid;
    end
    @(negedge clk); nss_v = '1; bus.i_req_nss = nss_v;
    repeat (4) @(negedge clk);

    // watchdog timeout on requester 1 with requester 3 pending
    nss_v = 4'b1101; bus.i_req_nss = nss_v;
    wait_active("to_active");
    check("to_gid", 32'(bus.o_grant_id), 32'd1);
    act = 1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (i == 0) begin nss_v = 4'b0101; bus.i_req_nss = nss_v; end
      #2;
      if (bus.o_timeout) ok = 1'b1;
      else if (!bus.o_alu_nss) act++;
    end
    check("to_seen",    32'(ok), 32'd1);
    check("to_cycles",  32'(act), 32'd8);
    check("to_alu_nss", 32'(bus.o_alu_nss), 32'd1);
    check("to_miso1",   32'(bus.o_req_miso[1]), 32'd1);
    check("to_gv",      32'(bus.o_grant_valid), 32'd1);
    @(negedge clk); #2;
    check("to_pulse_len", 32'(bus.o_timeout), 32'd0);
    repeat (2) @(negedge clk);
    @(negedge clk); nss_v[1] = 1'b1; bus.i_req_nss = nss_v;
    @(negedge clk); #2;
    check("to_release_gv", 32'(bus.o_grant_valid), 32'd0);
    @(negedge clk); #2;
    check("to_idle_gv", 32'(bus.o_grant_valid), 32'd0);
    @(negedge clk); #2;
    check("to_next_gv",  32'(bus.o_grant_valid), 32'd1);
    check("to_next_gid", 32'(bus.o_grant_id), 32'd3);
    repeat (3) @(negedge clk);
    @(negedge clk); nss_v = '1; bus.i_req_nss = nss_v;
    repeat (4) @(negedge clk);

    // release on the same cycle the watchdog expires
    nss_v = 4'b1110; bus.i_req_nss = nss_v;
    wait_active("col_active");
    repeat (6) @(negedge clk);
    @(negedge clk); nss_v[0] = 1'b1; bus.i_req_nss = nss_v;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      check("col_no_timeout", 32'(bus.o_timeout), 32'd0);
      if (i == 0) check("col_release_gv", 32'(bus.o_grant_valid), 32'd0);
    end

    // reset in the middle of requester 3's transaction
    nss_v = 4'b0111; bus.i_req_nss = nss_v;
    wait_active("mid_active");
    check("mid_gid", 32'(bus.o_grant_id), 32'd3);
    repeat (2) @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; nss_v = 4'b0110; bus.i_req_nss = nss_v; #2;
    check("mid_alu_nss", 32'(bus.o_alu_nss), 32'd1);
    check("mid_gv",      32'(bus.o_grant_valid), 32'd0);
    check("mid_timeout", 32'(bus.o_timeout), 32'd0);
    @(negedge clk); #2;
    check("mid_after_gv",  32'(bus.o_grant_valid), 32'd1);
    check("mid_after_gid", 32'(bus.o_grant_id), 32'd0);
    // request dropped during GRANT: one ACTIVE cycle, then RELEASE
    nss_v = '1; bus.i_req_nss = nss_v;
    @(negedge clk); #2;
    check("gdrop_active", 32'(bus.o_alu_nss), 32'd0);
    @(negedge clk); #2;
    check("gdrop_release", 32'(bus.o_grant_valid), 32'd0);
    repeat (3) @(negedge clk);

    // randomized traffic, including overlong holds and rare resets
    for (int i = 0; i < NR; i++) hold[i] = int'($urandom_range(6, 0));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(599, 0) == 0);
      for (int i = 0; i < NR; i++) begin
        if (hold[i] == 0) begin
          nss_v[i] = ~nss_v[i];
          hold[i]  = nss_v[i] ? int'($urandom_range(4, 1)) : int'($urandom_range(14, 1));
        end else begin
          hold[i]--;
        end
      end
      bus.i_req_nss = nss_v;
    end

    @(negedge clk); rst = 1'b0; nss_v = '1; bus.i_req_nss = nss_v;
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_link_arbiter.md
# alu_link_arbiter

Round-robin arbiter that shares the single serial ALU link between up to `NUM_REQUESTERS` processor-side SPI masters. It sits between the processors' `Spi` master ports and the ALU's slave port. It grants the link to one requester at a time and muxes `mosi`/`miso`, holding each grant for the full send/receive transaction. A watchdog revokes any grant that exceeds `TIMEOUT_CYCLES`. `sclk` is the shared system clock and is not routed through this block.

## Interface
- `NUM_REQUESTERS`, default 4: number of requesters. Legal range 2..16.
- `TIMEOUT_CYCLES`, default 256: maximum cycles a grant may remain in ACTIVE. Must be ≥ 2.
- `ID_W`, derived as `$clog2(NUM_REQUESTERS)`: width of the requester index.

Ports:
- `i_clock`  in  1: system clock; all logic on rising edge.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_req_nss`  in  NUM_REQUESTERS: per-requester slave select; low = request or transaction in progress.
- `i_req_mosi`  in  NUM_REQUESTERS: per-requester serial data toward the ALU.
- `o_req_miso`  out  NUM_REQUESTERS: per-requester serial data from the ALU; forced high when not connected.
- `o_alu_nss`  out  1: ALU slave select, active low.
- `o_alu_mosi`  out  1: serial data to the ALU.
- `i_alu_miso`  in  1: serial data from the ALU.
- `o_grant_valid`  out  1: high while a requester owns the link (GRANT/ACTIVE/ABORT).
- `o_grant_id`  out  ID_W: index of the current or last owner.
- `o_timeout`  out  1: one-cycle pulse when a grant is revoked.

## Operation
- **States:** IDLE, GRANT, ACTIVE, ABORT, RELEASE. All are registered; the muxes are combinational from the state and the registered `grant_id`.
- **IDLE:**
  - If any `i_req_nss` bit is low, select the first low bit searching upward from `(last_id+1) mod N`, with wrap-around.
  - Register it into `grant_id` and go to GRANT.
  - With no requests, remain in IDLE.
- **GRANT:** one settle cycle with `o_alu_nss`=1. Then go to ACTIVE unconditionally.
- **ACTIVE:**
  - `o_alu_nss`=0, `o_alu_mosi`=`i_req_mosi[grant_id]`, `o_req_miso[grant_id]`=`i_alu_miso`.
  - The watchdog counter increments each cycle.
  - Exit conditions, checked in this priority order:
    1. `i_req_nss[grant_id]`=1: go to RELEASE.
    2. Counter == `TIMEOUT_CYCLES-1`: go to ABORT and pulse `o_timeout` on entry.
- **ABORT:**
  - `o_alu_nss`=1, and the owner's miso is forced high.
  - Wait for `i_req_nss[grant_id]`=1, then go to RELEASE.
- **RELEASE:**
  - One cycle with `o_alu_nss`=1, which guarantees a ≥1-cycle nss-high gap at the ALU between owners.
  - Set `last_id`=`grant_id`, clear the counter, go to IDLE.
- **Non-owners:**
  - `o_req_miso` is forced to 1 in every state and for every non-owner. This holds a waiting master in its pre-send handshake.
  - Their `i_req_mosi` is ignored.
- `o_alu_mosi`=0 whenever the state is not ACTIVE.
- **Reset:**
  - State=IDLE, `last_id`=N-1 (so requester 0 wins first), `grant_id`=0, counter=0.
  - `o_alu_nss`=1, `o_alu_mosi`=0, `o_req_miso`=all 1, `o_grant_valid`=0, `o_grant_id`=0, `o_timeout`=0.
- **Reset mid-transaction:** reset aborts immediately. The next cycle shows `o_alu_nss`=1, with no RELEASE and no `o_timeout` pulse.
- **Simultaneous release and timeout** on the same cycle: release wins, and no `o_timeout` pulse is issued.
- A request dropped while the state is GRANT is treated as a release: GRANT→ACTIVE, then an immediate ACTIVE→RELEASE.

## Timing
- **Grant latency:** `i_req_nss[k]` sampled low at edge t gives GRANT after t, ACTIVE after t+1. `o_alu_nss` falls 2 cycles after the request is seen.
- **Data path in ACTIVE:** purely combinational mux, zero added latency. The bit-serial protocol timing between master and ALU is preserved exactly.
- **Release latency:** owner nss high at edge t gives RELEASE after t, IDLE after t+1. The earliest next grant enters GRANT after t+2. Minimum owner-to-owner gap on `o_alu_nss` is 3 cycles high (RELEASE, IDLE, GRANT).
- **Timeout:** `o_timeout` is high for exactly the single cycle when the state is ABORT entered from ACTIVE. This occurs `TIMEOUT_CYCLES` cycles after ACTIVE entry.
- Counter width is `$clog2(TIMEOUT_CYCLES)`, and it does not wrap within ACTIVE.

## Test plan
- **Reset values:** assert `i_reset` for 2 cycles with all `i_req_nss`=1. Require `o_alu_nss`=1, `o_req_miso`=4'b1111, `o_grant_valid`=0, `o_grant_id`=0, `o_timeout`=0.
- **Single requester:**
  - Stimulus: requester 2 drops nss; hold 20 cycles driving a mosi pattern; ALU drives a miso pattern.
  - Required: `o_alu_nss` low 2 cycles later; `o_grant_id`=2; `o_alu_mosi` tracks `i_req_mosi[2]`; `o_req_miso[2]` tracks `i_alu_miso`; other miso bits stay 1.
- **Round-robin fairness:** all 4 requesters hold nss low, and each releases after 10 ACTIVE cycles. Required grant order is 0,1,2,3,0, with a ≥1-cycle `o_alu_nss` high gap between owners.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYCLES`=8; requester 1 holds nss low indefinitely.
  - Required: after 8 ACTIVE cycles, `o_timeout` pulses for 1 cycle, `o_alu_nss`=1, and `o_req_miso[1]`=1. When requester 1 later raises nss, the state goes RELEASE then IDLE, and a pending requester 3 is granted next.
- **Release/timeout collision:** requester 0 raises nss exactly on the cycle the counter reaches 7 (`TIMEOUT_CYCLES`=8). Required: no `o_timeout`, normal RELEASE.
- **Reset mid-transaction:** assert `i_reset` during requester 3's ACTIVE phase. Required next cycle: `o_alu_nss`=1, `o_grant_valid`=0. After reset, with requesters 0 and 3 both requesting, requester 0 is granted first.
